// File: rtl/display_pkg.sv
// display_pkg: shared constants and helpers for the multiplexed seven-segment scanner.
// Segment order in every 7-bit code is {g,f,e,d,c,b,a}, active-low.
package display_pkg;

   localparam logic [7:0] SEG_OFF = 8'hFF;

   // Active-low glyphs for hex 0..F, entry 0 in the least significant slot.
   localparam logic [15:0][6:0] SEG_TABLE = {
      7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
      7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
      7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
      7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
   };

   // Width of a digit index; never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational hex nibble to active-low seven-segment code.
module seg7_decode
   import display_pkg::*;
(
   input  logic [3:0] nibble_i,
   output logic [6:0] seg_o
);

   // Pure table lookup; the dp bit is handled by the caller.
   always_comb begin
      seg_o = SEG_TABLE[nibble_i];
   end

endmodule

// File: rtl/display_scan.sv
// display_scan: multiplexed common-anode seven-segment scanner with PWM dimming,
// frame-synchronous snapshot of value/dp, and registered active-low outputs.
// Optional leading-zero blanking is built when DISPLAY_SCAN_LZB_EN is defined.
module display_scan
   import display_pkg::*;
#(
   parameter int DIGITS   = 4,
   parameter int SCAN_W   = 15,
   parameter int BRIGHT_W = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [4*DIGITS-1:0]   value,
   input  logic [DIGITS-1:0]     dp,
   input  logic                  enable,
   input  logic [BRIGHT_W-1:0]   brightness,
   output logic [DIGITS-1:0]     io_select,
   output logic [7:0]            io_segment,
   output logic                  frame_tick
);

   localparam int            IW       = idx_width(DIGITS);
   localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

   logic [SCAN_W-1:0]   pre_q, pre_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic [4*DIGITS-1:0] snap_val_q;
   logic [DIGITS-1:0]   snap_dp_q;
   logic [DIGITS-1:0]   sel_q, sel_d;
   logic [7:0]          seg_q, seg_d;
   logic                tick_q, tick_d;
   logic                wrap, frame_start, lit;
   logic [3:0]          nibble;
   logic [6:0]          glyph;
   logic [DIGITS-1:0]   blank;

   seg7_decode u_dec (
      .nibble_i (nibble),
      .seg_o    (glyph)
   );

`ifdef DISPLAY_SCAN_LZB_EN
   // Reset snapshot is all zeros, so every digit above 0 starts blanked.
   localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

   logic [DIGITS-1:0] blank_q, blank_d;

   // Walk down from the top digit; blanking stops at the first non-zero nibble or set dp.
   always_comb begin
      logic run;
      run     = 1'b1;
      blank_d = '0;
      for (int i = DIGITS - 1; i > 0; i--) begin
         if (run && (snap_val_q[4*i +: 4] == 4'h0) && !snap_dp_q[i]) begin
            blank_d[i] = 1'b1;
         end else begin
            run = 1'b0;
         end
      end
   end

   // Mask is refreshed once per frame, the clock after the snapshot is taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blank_q <= BLANK_RST;
      end else if (tick_q) begin
         blank_q <= blank_d;
      end
   end

   assign blank = blank_q;
`else
   assign blank = '0;
`endif

   // Scan position, snapshot selection and the lit/dark decision for the current slot.
   always_comb begin
      wrap        = &pre_q;
      frame_start = wrap && (idx_q == LAST_IDX);
      pre_d       = pre_q + 1'b1;
      idx_d       = idx_q;
      if (wrap) begin
         idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
      end
      tick_d = frame_start;
      nibble = snap_val_q[{idx_q, 2'b00} +: 4];
      lit    = enable && !blank[idx_q]
               && (pre_q[SCAN_W-1 -: BRIGHT_W] <= brightness);
      sel_d  = '1;
      seg_d  = SEG_OFF;
      if (lit) begin
         sel_d[idx_q] = 1'b0;
         seg_d        = {~snap_dp_q[idx_q], glyph};
      end
   end

   // Prescaler, digit index and frame-boundary snapshot of the display data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_q      <= '0;
         idx_q      <= '0;
         snap_val_q <= '0;
         snap_dp_q  <= '0;
      end else begin
         pre_q <= pre_d;
         idx_q <= idx_d;
         if (frame_start) begin
            snap_val_q <= value;
            snap_dp_q  <= dp;
         end
      end
   end

   // Registered pin drivers; select and segments always change on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_q  <= '1;
         seg_q  <= SEG_OFF;
         tick_q <= 1'b0;
      end else begin
         sel_q  <= sel_d;
         seg_q  <= seg_d;
         tick_q <= tick_d;
      end
   end

   assign io_select  = sel_q;
   assign io_segment = seg_q;
   assign frame_tick = tick_q;

endmodule

// File: tb/tb_display_scan.sv
// Directed bench for display_scan (SCAN_W=4, BRIGHT_W=2) with a 4-digit and an 8-digit instance.
// Expectations follow DISPLAY_SCAN_LZB_EN when the build defines it.
module tb_display_scan;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] value = '0;
   logic [3:0]  dp = '0;
   logic        enable = 1'b1;
   logic [1:0]  brightness = 2'd3;
   logic [3:0]  io_select;
   logic [7:0]  io_segment;
   logic        frame_tick;

   logic [31:0] value8 = 32'h89ABCDEF;
   logic [7:0]  dp8 = '0;
   logic [7:0]  io_select8;
   logic [7:0]  io_segment8;
   logic        frame_tick8;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   display_scan #(.DIGITS(4), .SCAN_W(4), .BRIGHT_W(2)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .value      (value),
      .dp         (dp),
      .enable     (enable),
      .brightness (brightness),
      .io_select  (io_select),
      .io_segment (io_segment),
      .frame_tick (frame_tick)
   );

   display_scan #(.DIGITS(8), .SCAN_W(4), .BRIGHT_W(2)) u_dut8 (
      .clk        (clk),
      .rst_n      (rst_n),
      .value      (value8),
      .dp         (dp8),
      .enable     (enable),
      .brightness (brightness),
      .io_select  (io_select8),
      .io_segment (io_segment8),
      .frame_tick (frame_tick8)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reset released on a falling edge; the next rising edge is edge 1.
   task automatic reset_dut();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      int cnt;
      value = 16'h1234; dp = 4'h0; enable = 1'b1; brightness = 2'd3;
      reset_dut();
      repeat (5) tick();
      n_cmp++;
      if (io_select !== 4'b1110) begin
         n_err++; $display("FAIL reset_pre_sel actual=%b required=%b", io_select, 4'b1110);
      end
      n_cmp++;
      if (io_segment !== 8'hC0) begin
         n_err++; $display("FAIL reset_pre_seg actual=%h required=%h", io_segment, 8'hC0);
      end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if (io_select !== 4'b1111) begin
         n_err++; $display("FAIL reset_async_sel actual=%b required=%b", io_select, 4'b1111);
      end
      n_cmp++;
      if (io_segment !== 8'hFF) begin
         n_err++; $display("FAIL reset_async_seg actual=%h required=%h", io_segment, 8'hFF);
      end
      n_cmp++;
      if (frame_tick !== 1'b0) begin
         n_err++; $display("FAIL reset_async_tick actual=%b required=0", frame_tick);
      end
      @(negedge clk);
      rst_n = 1'b1;
      cnt = 0;
      while (cnt < 200) begin
         tick();
         cnt++;
         if (frame_tick === 1'b1) break;
      end
      n_cmp++;
      if (cnt !== 64) begin
         n_err++; $display("FAIL reset_first_tick actual=%0d required=64", cnt);
      end
   endtask

   task automatic test_scan();
      logic [7:0] exp_seg [4];
      logic [3:0] es;
      exp_seg[0] = 8'h8E; exp_seg[1] = 8'hA4; exp_seg[2] = 8'h08; exp_seg[3] = 8'hF9;
      value = 16'h1A2F; dp = 4'b0100; enable = 1'b1; brightness = 2'd3;
      reset_dut();
      repeat (64) tick();
      n_cmp++;
      if (frame_tick !== 1'b1) begin
         n_err++; $display("FAIL scan_tick actual=%b required=1", frame_tick);
      end
      for (int j = 0; j < 64; j++) begin
         tick();
         es = 4'hF; es[j/16] = 1'b0;
         n_cmp++;
         if (io_select !== es) begin
            n_err++; $display("FAIL scan_sel j=%0d actual=%b required=%b", j, io_select, es);
         end
         n_cmp++;
         if (io_segment !== exp_seg[j/16]) begin
            n_err++; $display("FAIL scan_seg j=%0d actual=%h required=%h", j, io_segment, exp_seg[j/16]);
         end
      end
   endtask

   task automatic test_tearing();
      value = 16'h1111; dp = 4'h0; enable = 1'b1; brightness = 2'd3;
      reset_dut();
      repeat (64) tick();
      for (int j = 0; j < 64; j++) begin
         if (j == 36) value = 16'h2222;
         tick();
         n_cmp++;
         if (io_segment !== 8'hF9) begin
            n_err++; $display("FAIL tear_old j=%0d actual=%h required=%h", j, io_segment, 8'hF9);
         end
      end
      for (int j = 0; j < 64; j++) begin
         if (j == 63) value = 16'h3333;
         tick();
         n_cmp++;
         if (io_segment !== 8'hA4) begin
            n_err++; $display("FAIL tear_new j=%0d actual=%h required=%h", j, io_segment, 8'hA4);
         end
      end
      n_cmp++;
      if (frame_tick !== 1'b1) begin
         n_err++; $display("FAIL tear_tick actual=%b required=1", frame_tick);
      end
      tick();
      n_cmp++;
      if (io_segment !== 8'hB0) begin
         n_err++; $display("FAIL tear_boundary actual=%h required=%h", io_segment, 8'hB0);
      end
      n_cmp++;
      if (io_select !== 4'b1110) begin
         n_err++; $display("FAIL tear_boundary_sel actual=%b required=%b", io_select, 4'b1110);
      end
   endtask

   task automatic test_brightness();
      logic [3:0] es;
      value = 16'h1A2F; dp = 4'b0100; enable = 1'b1; brightness = 2'd1;
      reset_dut();
      repeat (64) tick();
      for (int j = 0; j < 64; j++) begin
         tick();
         es = 4'hF;
         if ((j % 16) < 8) es[j/16] = 1'b0;
         n_cmp++;
         if (io_select !== es) begin
            n_err++; $display("FAIL bright1_sel j=%0d actual=%b required=%b", j, io_select, es);
         end
      end
      enable = 1'b0;
      for (int j = 0; j < 64; j++) begin
         tick();
         n_cmp++;
         if (io_select !== 4'hF || io_segment !== 8'hFF) begin
            n_err++; $display("FAIL disabled j=%0d actual=%b/%h required=1111/ff", j, io_select, io_segment);
         end
      end
      enable = 1'b1; brightness = 2'd0;
      for (int j = 0; j < 64; j++) begin
         tick();
         es = 4'hF;
         if ((j % 16) < 4) es[j/16] = 1'b0;
         n_cmp++;
         if (io_select !== es) begin
            n_err++; $display("FAIL bright0_sel j=%0d actual=%b required=%b", j, io_select, es);
         end
      end
      brightness = 2'd3;
   endtask

   task automatic test_lzb();
      logic [15:0] vals [3];
      logic [3:0]  dps  [3];
      logic [3:0]  lit  [3];
      logic [7:0]  segs [3][4];
      logic [3:0]  es;
      logic [7:0]  eg;
      vals[0] = 16'h0050; dps[0] = 4'b0000;
      vals[1] = 16'h0000; dps[1] = 4'b0000;
      vals[2] = 16'h0000; dps[2] = 4'b0100;
      segs[0][0] = 8'hC0; segs[0][1] = 8'h92; segs[0][2] = 8'hC0; segs[0][3] = 8'hC0;
      segs[1][0] = 8'hC0; segs[1][1] = 8'hC0; segs[1][2] = 8'hC0; segs[1][3] = 8'hC0;
      segs[2][0] = 8'hC0; segs[2][1] = 8'hC0; segs[2][2] = 8'h40; segs[2][3] = 8'hC0;
`ifdef DISPLAY_SCAN_LZB_EN
      lit[0] = 4'b0011; lit[1] = 4'b0001; lit[2] = 4'b0111;
`else
      lit[0] = 4'b1111; lit[1] = 4'b1111; lit[2] = 4'b1111;
`endif
      value = vals[0]; dp = dps[0]; enable = 1'b1; brightness = 2'd3;
      reset_dut();
      repeat (64) tick();
      for (int s = 0; s < 3; s++) begin
         for (int j = 0; j < 64; j++) begin
            if (j == 32 && s < 2) begin
               value = vals[s+1]; dp = dps[s+1];
            end
            tick();
            es = 4'hF; eg = 8'hFF;
            if (lit[s][j/16]) begin
               es[j/16] = 1'b0;
               eg = segs[s][j/16];
            end
            n_cmp++;
            if (io_select !== es || io_segment !== eg) begin
               n_err++; $display("FAIL lzb s=%0d j=%0d actual=%b/%h required=%b/%h", s, j, io_select, io_segment, es, eg);
            end
         end
      end
   endtask

   task automatic test_param();
      logic [7:0] exp_seg [8];
      logic [7:0] es;
      exp_seg[0] = 8'h8E; exp_seg[1] = 8'h86; exp_seg[2] = 8'hA1; exp_seg[3] = 8'hC6;
      exp_seg[4] = 8'h83; exp_seg[5] = 8'h88; exp_seg[6] = 8'h90; exp_seg[7] = 8'h80;
      value8 = 32'h89ABCDEF; dp8 = 8'h00; enable = 1'b1; brightness = 2'd3;
      reset_dut();
      repeat (127) tick();
      n_cmp++;
      if (frame_tick8 !== 1'b0) begin
         n_err++; $display("FAIL p8_early_tick actual=%b required=0", frame_tick8);
      end
      tick();
      n_cmp++;
      if (frame_tick8 !== 1'b1) begin
         n_err++; $display("FAIL p8_first_tick actual=%b required=1", frame_tick8);
      end
      for (int j = 0; j < 128; j++) begin
         tick();
         es = 8'hFF; es[j/16] = 1'b0;
         n_cmp++;
         if (io_select8 !== es || io_segment8 !== exp_seg[j/16]) begin
            n_err++; $display("FAIL p8_scan j=%0d actual=%b/%h required=%b/%h", j, io_select8, io_segment8, es, exp_seg[j/16]);
         end
         n_cmp++;
         if (frame_tick8 !== (j == 127)) begin
            n_err++; $display("FAIL p8_tick j=%0d actual=%b required=%b", j, frame_tick8, (j == 127));
         end
      end
   endtask

   initial begin
      test_reset();
      test_scan();
      test_tearing();
      test_brightness();
      test_lzb();
      test_param();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired actual=running required=finished");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/display_scan.md
# display_scan

Parametrised multiplexed seven-segment driver: scans `DIGITS` common-anode digits from a packed hex word, with per-digit decimal points, PWM brightness, frame-synchronous input capture and optional leading-zero blanking. It sits between any register/bus value in the design and the board's `io_select`/`io_segment` pins. It replaces the fixed 4-digit scanner for boards with more digits or dimming needs.

## Interface
Parameters:
- `DIGITS`, 4: number of digits scanned; legal range 2..16.
- `SCAN_W`, 15: slot-length exponent; each digit slot lasts 2^SCAN_W clocks.
- `BRIGHT_W`, 3: brightness code width; must satisfy 1 <= BRIGHT_W <= SCAN_W.

Ports:
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `value`, in, 4*DIGITS: hex nibbles; bits [3:0] are digit 0, the rightmost digit.
- `dp`, in, DIGITS: decimal-point request per digit; bit i is digit i.
- `enable`, in, 1: display on; when low, all digits are dark.
- `brightness`, in, BRIGHT_W: on-time code; all ones gives full duty.
- `io_select`, out, DIGITS: digit enables, active-low, one-hot-low.
- `io_segment`, out, 8: segments {dp,g,f,e,d,c,b,a}, active-low.
- `frame_tick`, out, 1: one-cycle pulse when a new frame starts.

## Operation
- Prescaler `pre` (SCAN_W bits) increments every clock and wraps from 2^SCAN_W−1 to 0.
- When `pre` wraps, digit index `idx` advances. It goes from DIGITS−1 back to 0.
- Snapshot: when `idx` moves to 0, `value` and `dp` are copied into `snap_val`/`snap_dp`. All display data comes from the snapshot, so there is no tearing mid-frame. `frame_tick` pulses on the same clock.
- Lit condition for the current slot: `enable` is 1, the digit is not blanked, and `pre[SCAN_W-1 -: BRIGHT_W] <= brightness`. Duty = (brightness+1)/2^BRIGHT_W.
- When lit:
  - `io_select` = all ones with bit `idx` cleared.
  - `io_segment` = decode(snap_val nibble `idx`), with bit 7 = ~snap_dp[idx].
- When not lit: `io_select` = all ones and `io_segment` = 8'hFF.
- `enable`, `brightness` and `pre` are used live, not from the snapshot. Scanning continues while `enable` is low.

## Timing
- Reset values: `pre`=0, `idx`=0, snapshot=0, `io_select`=all ones, `io_segment`=8'hFF, `frame_tick`=0.
- Reset assertion forces these values immediately, without waiting for a clock.
- `io_select`/`io_segment` are registered. They reflect the `pre`/`idx` state of the previous clock, so latency is 1 cycle.
- After reset release, the first snapshot and `frame_tick` occur at the first wrap to idx 0. This is DIGITS·2^SCAN_W clocks after release. Until then the snapshot shows 0 ("0" on every digit, subject to blanking).
- Digit switchover: `io_select` never has two bits low at once. Select and segments update on the same edge.
- A change on `value` mid-frame has no effect until the next frame boundary. A change on the boundary clock itself is captured.
- brightness = all ones: the digit is continuously lit for the whole slot. brightness = 0: lit for the first 2^(SCAN_W−BRIGHT_W) clocks of the slot.
- `enable` falling: outputs go dark on the next clock edge.

## Configuration
- Macro: `DISPLAY_SCAN_LZB_EN`.
- When defined, leading-zero blanking is active:
  - Scanning from digit DIGITS−1 downward, a digit is blanked while its snapshot nibble is 0 and its snapshot dp is 0.
  - The first non-zero nibble or set dp stops blanking for that digit and all lower digits.
  - Digit 0 is never blanked.
  - Blanked digits are dark for the whole slot.
- When undefined: no digit is ever blanked, and the blank logic is absent.

## Structure
- Package `display_pkg`:
  - 16-entry active-low segment constant table (hex 0–F).
  - `SEG_OFF` = 8'hFF.
  - Index-width helper function (clog2 of DIGITS, minimum 1).
- One sub-module: `seg7_decode`. It is combinational, takes a 4-bit nibble and outputs 7 active-low segments from the package table.
- Blank mask: computed once per frame from the snapshot as a DIGITS-bit register, updated on the clock after the snapshot.

## Test plan
- Reset: rst_n=0 mid-slot → `io_select`=4'b1111, `io_segment`=8'hFF at once with no clock edge. After release, first `frame_tick` at 4·2^SCAN_W clocks (SCAN_W=4 on the bench gives 64).
- Scan: value=16'h1A2F, dp=4'b0100, brightness=all ones, enable=1. Over one frame, expect this sequence, each 2^SCAN_W clocks long:
  - select 1110 / segment F
  - select 1101 / segment 2
  - select 1011 / segment A with dp low
  - select 0111 / segment 1
- Tearing: change value from 16'h1111 to 16'h2222 during digit 2 → the rest of the frame still shows 1. The next frame shows 2 from digit 0 onward.
- Brightness: SCAN_W=4, BRIGHT_W=2, brightness=1 → each digit has select low for 8 of 16 slot clocks, namely `pre` 0–7. With enable=0, select stays 1111 throughout.
- LZB (macro defined): value=16'h0050, dp=0 → digits 3 and 2 dark all frame, digits 1 and 0 show 5 and 0. value=16'h0000 → only digit 0 lit, showing "0". value=16'h0000 with dp=4'b0100 → digits 2..0 lit.
- Parametrisation: DIGITS=8, value=32'h89ABCDEF → eight slots per frame, with `frame_tick` period 8·2^SCAN_W.
